tpu_shared_res_arbiter: RTL and testbench
=========================================

// Module: tpu_shared_res_arbiter
// PURPOSE
//  Grants exclusive, lock-until-release ownership of the shared weight ROM read port and the shared
//  128-lane MultAdder to one of two layer engines (req 0 = FC1, req 1 = FC2).
//  Muxes the owner's address and operands onto the shared resources; routes ROM data and MAC results back.
//  Replaces tristate bus sharing with explicit muxing; the top-level sequencer drives the engines.
// PARAMETERS
//  BIT      16   lane word width (bits)
//  LANES    128  operand lanes per ROM word / MultAdder input
//  ADDR_W   11   ROM address width
//  ROM_LAT  1    ROM read latency, in cycles from rom_en to rom_data valid (range 1..4)
// PORTS
//  clk           in   1              clock; everything samples on posedge
//  iRst          in   1              synchronous, active-high reset
//  req           in   2              per-engine ownership request (level)
//  rel           in   2              per-engine release pulse; ignored unless from the current owner
//  rd_en         in   2              per-engine ROM read strobe
//  addr0/addr1   in   ADDR_W         per-engine ROM address
//  mac_vld       in   2              per-engine "operands valid this cycle"
//  opa0/opa1     in   LANES*BIT      per-engine MultAdder operand 1
//  opb0/opb1     in   LANES*BIT      per-engine MultAdder operand 2
//  rom_en        out  1              shared ROM read enable
//  rom_addr      out  ADDR_W         shared ROM address
//  rom_data      in   LANES*BIT      shared ROM read data
//  mac_a/mac_b   out  LANES*BIT      shared MultAdder operands
//  mac_res       in   2*BIT-1        shared MultAdder result (combinational)
//  mac_ovf       in   1              shared MultAdder overflow flag
//  gnt           out  2              one-hot grant; 00 when no owner
//  rd_data       out  LANES*BIT      rom_data broadcast to both engines
//  rd_valid      out  2              rd_data valid, set only for the engine that issued the read
//  res_data      out  2*BIT-1        mac_res broadcast to both engines
//  ovf           out  2              sticky per-engine overflow
//  ovf_clr       in   2              clear for the matching ovf bit
//  busy          out  1              high whenever state != IDLE
// BEHAVIOUR
//  - States: IDLE, OWN (owner id held in a register), DRAIN (ROM_LAT-cycle counter).
//  - Reset values: gnt=0, rom_en=0, rom_addr=0, mac_a=mac_b=0, rd_valid=0, ovf=0, busy=0.
//    Reset also flushes the read-tag pipeline and sets the round-robin pointer so engine 0 wins first.
//  - IDLE: any req bit set at cycle N gives gnt one-hot at N+1 and moves to OWN.
//    Tie between both requesters: the engine not granted last wins (round robin).
//  - OWN: while owning, the other engine's req, rd_en, mac_vld and rel are ignored.
//    rom_en = rd_en[owner] & gnt, combinational. rom_addr follows addr of the owner, or 0 with no owner.
//    mac_a/mac_b = owner operands, or 0 with no owner. Non-owner inputs never reach the outputs.
//  - Read tagging: each issued read pushes the owner id into a ROM_LAT-deep shift register.
//    rd_valid[id] is 1 exactly ROM_LAT cycles after the read issues, one cycle per read.
//  - rel[owner] at cycle N: gnt=00 at N+1, state goes to DRAIN for ROM_LAT cycles, then IDLE.
//    Data from reads already in flight still reaches the old owner.
//    Next grant is at N+ROM_LAT+2 at the earliest.
//  - rel and rd_en from the owner in the same cycle: the read issues, then the release takes effect.
//  - rel and req both held by the owner in the same cycle: release wins. The engine re-arbitrates after DRAIN.
//  - Overflow: ovf[owner] is set when mac_vld[owner] & mac_ovf & gnt[owner].
//    Set wins over a simultaneous ovf_clr. Bits persist across grants until cleared.
//  - Arithmetic: none beyond muxing. Widths are passed through unchanged.
//  - Reset mid-operation (OWN or DRAIN): next cycle gnt=0, rd_valid=0, state IDLE.
//    In-flight read data is dropped.
// STRUCTURE
//  - Shared package tpu_pkg: BIT, LANES, ADDR_W, state encodings, and REQ_FC1=0 / REQ_FC2=1.
//  - Sub-module rr_arbiter_2: 2-way round-robin pick with the pointer register; outputs a one-hot winner.
//  - Top contains the FSM, owner muxes, read-tag shift register and overflow bits.
// TESTING
//  1. Reset, then req=01: gnt=01 next cycle. rd_en0 with addr0=0x005: rom_addr=0x005, rom_en=1,
//     rd_valid=01 after ROM_LAT cycles.
//  2. req=11 from IDLE, twice in a row with release between: first gnt=01, second gnt=10 (round robin).
//  3. Owner 0 releases while its read to 0x3FF is in flight: rd_valid[0]=1 during DRAIN, gnt=00.
//     req1 is granted at N+ROM_LAT+2.
//  4. Owner 1 with mac_vld1 & mac_ovf=1: ovf=10, ovf[0] unchanged.
//     ovf_clr=10 with a new overflow in the same cycle: ovf stays 10. Next clear gives 00.
//  5. Non-owner drives rd_en, rel and opa=all-ones: rom_en=0, mac_a=0 or owner data, gnt unchanged.
//  6. iRst asserted in OWN with a read in flight: next cycle gnt=00, rd_valid=00, busy=0.
//     The expected rd_valid pulse never appears.

Source files
------------

// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
// Shared constants and types for the TPU shared-resource arbiter slice.
//   BIT      lane word width
//   LANES    operand lanes per ROM word / MultAdder input
//   ADDR_W   weight ROM address width
//   WORD_W   full ROM word / operand vector width (LANES*BIT)
//   RES_W    MultAdder result width (2*BIT-1)
//   REQ_FC1 / REQ_FC2   requester indices of the two layer engines
// -----------------------------------------------------------------------------
package tpu_pkg;

    localparam int BIT     = 16;
    localparam int LANES   = 128;
    localparam int ADDR_W  = 11;
    localparam int WORD_W  = LANES * BIT;
    localparam int RES_W   = 2 * BIT - 1;

    localparam int REQ_FC1 = 0;
    localparam int REQ_FC2 = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    // One-hot engine mask for a single-bit engine id.
    function automatic logic [1:0] id_to_onehot(input logic id);
        return (id == 1'(REQ_FC2)) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/tpu_shared_res_arbiter_if.sv
// -----------------------------------------------------------------------------
// tpu_shared_res_arbiter_if
// Bundles the two engine request/operand ports, the shared ROM read port and
// the shared MultAdder port around the arbiter.
//   slave  : arbiter view (engine + resource inputs in, muxed outputs out)
//   master : environment view (engines and shared resources)
// Engine side : req, rel, rd_en, addr0/1, mac_vld, opa0/1, opb0/1, ovf_clr in;
//               gnt, rd_data, rd_valid, res_data, ovf, busy out.
// Resource side: rom_en, rom_addr, mac_a, mac_b out; rom_data, mac_res, mac_ovf in.
// -----------------------------------------------------------------------------
interface tpu_shared_res_arbiter_if;
    import tpu_pkg::*;

    // engine requests and operands
    logic [1:0]        req;
    logic [1:0]        rel;
    logic [1:0]        rd_en;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [1:0]        mac_vld;
    logic [WORD_W-1:0] opa0;
    logic [WORD_W-1:0] opa1;
    logic [WORD_W-1:0] opb0;
    logic [WORD_W-1:0] opb1;
    logic [1:0]        ovf_clr;

    // shared ROM port
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data;

    // shared MultAdder port
    logic [WORD_W-1:0] mac_a;
    logic [WORD_W-1:0] mac_b;
    logic [RES_W-1:0]  mac_res;
    logic              mac_ovf;

    // engine returns
    logic [1:0]        gnt;
    logic [WORD_W-1:0] rd_data;
    logic [1:0]        rd_valid;
    logic [RES_W-1:0]  res_data;
    logic [1:0]        ovf;
    logic              busy;

    modport slave (
        input  req, rel, rd_en, addr0, addr1, mac_vld,
               opa0, opa1, opb0, opb1, ovf_clr,
               rom_data, mac_res, mac_ovf,
        output rom_en, rom_addr, mac_a, mac_b,
               gnt, rd_data, rd_valid, res_data, ovf, busy
    );

    modport master (
        output req, rel, rd_en, addr0, addr1, mac_vld,
               opa0, opa1, opb0, opb1, ovf_clr,
               rom_data, mac_res, mac_ovf,
        input  rom_en, rom_addr, mac_a, mac_b,
               gnt, rd_data, rd_valid, res_data, ovf, busy
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin picker. A single requester always wins; on a tie the
// engine that was not granted last wins. The pointer only moves when the
// caller actually takes the grant.
//   clk, iRst : clock, synchronous active-high reset (engine 0 preferred)
//   req       : request vector
//   take      : grant consumed this cycle, update the pointer
//   win       : one-hot winner (00 when req is 00)
// -----------------------------------------------------------------------------
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       iRst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] win
);

    // index of the engine preferred on the next tie
    logic ptr_q;

    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (iRst) begin
            ptr_q <= 1'b0;
        end else if (take && (req != 2'b00)) begin
            // prefer the loser next time
            ptr_q <= ~win[1];
        end
    end

endmodule

// File: rtl/tpu_shared_res_arbiter.sv
// -----------------------------------------------------------------------------
// tpu_shared_res_arbiter
// Lock-until-release owner arbitration of the shared weight ROM read port and
// the shared 128-lane MultAdder between FC1 (engine 0) and FC2 (engine 1).
// The owner's address and operands are muxed onto the shared resources; ROM
// data and MAC results are broadcast back, with rd_valid steered to the engine
// that issued each read and sticky per-engine overflow bits.
//   clk   : clock
//   iRst  : synchronous active-high reset
//   bus   : tpu_shared_res_arbiter_if.slave (engine and resource signals)
//   ROM_LAT : ROM read latency, rom_en to rom_data valid (1..4)
// -----------------------------------------------------------------------------
module tpu_shared_res_arbiter
    import tpu_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   iRst,
    tpu_shared_res_arbiter_if.slave bus
);

    localparam int CNT_W = 2;

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              take;
    logic [1:0]        win;
    logic              own;
    logic [1:0]        gnt;
    logic              rom_en;

    // read-tag shift register: valid bit and issuing engine per stage
    logic [ROM_LAT-1:0] tag_vld;
    logic [ROM_LAT-1:0] tag_id;

    logic [1:0]        ovf_q;
    logic [1:0]        ovf_set;

    rr_arbiter_2 u_rr (
        .clk  (clk),
        .iRst (iRst),
        .req  (bus.req),
        .take (take),
        .win  (win)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    state_d = ST_OWN;
                    owner_d = (win == 2'b10);
                    take    = 1'b1;
                end
            end
            ST_OWN: begin
                // release beats a still-held request; a read in the same
                // cycle has already issued through rom_en below
                if (bus.rel[owner_q]) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(ROM_LAT - 1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- owner muxes
    assign own    = (state_q == ST_OWN);
    assign gnt    = own ? id_to_onehot(owner_q) : 2'b00;
    assign rom_en = own & bus.rd_en[owner_q];

    assign bus.gnt      = gnt;
    assign bus.rom_en   = rom_en;
    assign bus.rom_addr = !own ? '0 : ((owner_q == 1'(REQ_FC2)) ? bus.addr1 : bus.addr0);
    assign bus.mac_a    = !own ? '0 : ((owner_q == 1'(REQ_FC2)) ? bus.opa1  : bus.opa0);
    assign bus.mac_b    = !own ? '0 : ((owner_q == 1'(REQ_FC2)) ? bus.opb1  : bus.opb0);
    assign bus.rd_data  = bus.rom_data;
    assign bus.res_data = bus.mac_res;
    assign bus.busy     = (state_q != ST_IDLE);

    // ----------------------------------------------------- read-tag pipeline
    // Valid bits are control and get flushed by reset, which drops any
    // in-flight read; the id bits only matter while their valid is set.
    always_ff @(posedge clk) begin
        if (iRst) begin
            tag_vld <= '0;
        end else begin
            tag_vld <= ROM_LAT'({tag_vld, rom_en});
        end
    end

    always_ff @(posedge clk) begin
        tag_id <= ROM_LAT'({tag_id, owner_q});
    end

    assign bus.rd_valid = tag_vld[ROM_LAT-1] ? id_to_onehot(tag_id[ROM_LAT-1]) : 2'b00;

    // ------------------------------------------------------------ overflow
    // a new overflow in the same cycle as its clear keeps the bit set
    assign ovf_set = gnt & bus.mac_vld & {2{bus.mac_ovf}};

    always_ff @(posedge clk) begin
        if (iRst) begin
            ovf_q <= 2'b00;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~bus.ovf_clr);
        end
    end

    assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_tpu_shared_res_arbiter.sv
module tb_tpu_shared_res_arbiter;
    import tpu_pkg::*;

    localparam int ROM_LAT = 2;

    logic clk = 1'b0;
    logic iRst = 1'b1;
    always #5 clk = ~clk;

    tpu_shared_res_arbiter_if bus ();

    tpu_shared_res_arbiter #(.ROM_LAT(ROM_LAT)) dut (
        .clk  (clk),
        .iRst (iRst),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model (cycle-numbered, event based)
    typedef struct { int due; int id; } read_t;
    read_t    m_reads[$];
    int       m_owner   = -1;   // -1: nobody owns
    int       m_idle_at = 0;    // first cycle arbitration may happen again
    int       m_last    = 1;    // last granted engine (1 => engine 0 wins a tie)
    bit [1:0] m_ovf     = 2'b00;
    int       cyc       = 0;

    logic [1:0]        exp_gnt, exp_rd_valid, exp_ovf;
    logic              exp_rom_en, exp_busy;
    logic [ADDR_W-1:0] exp_rom_addr;
    logic [WORD_W-1:0] exp_mac_a, exp_mac_b;

    function automatic logic [WORD_W-1:0] rand_word();
        logic [WORD_W-1:0] w;
        for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic clear_inputs();
        bus.req = 2'b00; bus.rel = 2'b00; bus.rd_en = 2'b00; bus.mac_vld = 2'b00;
        bus.ovf_clr = 2'b00; bus.addr0 = '0; bus.addr1 = '0;
        bus.opa0 = '0; bus.opa1 = '0; bus.opb0 = '0; bus.opb1 = '0;
        bus.rom_data = '0; bus.mac_res = '0; bus.mac_ovf = 1'b0;
    endtask

    task automatic model_update();
        int w;
        if (iRst) begin
            m_owner = -1; m_idle_at = 0; m_last = 1; m_ovf = 2'b00;
            m_reads.delete();
        end else begin
            if (m_owner == 0 && bus.rd_en[0]) m_reads.push_back('{due: cyc + ROM_LAT, id: 0});
            if (m_owner == 1 && bus.rd_en[1]) m_reads.push_back('{due: cyc + ROM_LAT, id: 1});
            for (int i = 0; i < 2; i++) begin
                if (m_owner == i && bus.mac_vld[i] && bus.mac_ovf) m_ovf[i] = 1'b1;
                else if (bus.ovf_clr[i]) m_ovf[i] = 1'b0;
            end
            if (m_owner >= 0) begin
                if (bus.rel[m_owner]) begin
                    m_owner   = -1;
                    m_idle_at = cyc + 1 + ROM_LAT;
                end
            end else if (cyc >= m_idle_at && bus.req != 2'b00) begin
                if (bus.req == 2'b11) w = 1 - m_last;
                else w = bus.req[1] ? 1 : 0;
                m_owner = w;
                m_last  = w;
            end
            while (m_reads.size() > 0 && m_reads[0].due <= cyc) void'(m_reads.pop_front());
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic settle();
        #1;
        exp_gnt = 2'b00; exp_rom_en = 1'b0; exp_rom_addr = '0; exp_mac_a = '0; exp_mac_b = '0;
        if (m_owner == 0) begin
            exp_gnt = 2'b01; exp_rom_en = bus.rd_en[0]; exp_rom_addr = bus.addr0;
            exp_mac_a = bus.opa0; exp_mac_b = bus.opb0;
        end else if (m_owner == 1) begin
            exp_gnt = 2'b10; exp_rom_en = bus.rd_en[1]; exp_rom_addr = bus.addr1;
            exp_mac_a = bus.opa1; exp_mac_b = bus.opb1;
        end
        exp_rd_valid = 2'b00;
        foreach (m_reads[i]) if (m_reads[i].due == cyc) exp_rd_valid[m_reads[i].id] = 1'b1;
        exp_busy = (m_owner >= 0) || (cyc < m_idle_at);
        exp_ovf  = m_ovf;
    endtask

    task automatic release_owner(input int id);
        bus.req = 2'b00;
        bus.rel = (id == 1) ? 2'b10 : 2'b01;
        settle();
        tick();
        bus.rel = 2'b00;
        repeat (ROM_LAT) tick();
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        clear_inputs();
        iRst = 1'b1;
        tick(); tick();
        iRst = 1'b0;
        bus.opa0 = rand_word();
        settle();
        checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b want=00", bus.gnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.rom_en !== 1'b0 || bus.rom_addr !== '0) begin errors++; $display("FAIL reset_rom got en=%b addr=%h want 0/0", bus.rom_en, bus.rom_addr); end
        checks++; if (bus.mac_a !== '0 || bus.mac_b !== '0) begin errors++; $display("FAIL reset_mac got a[31:0]=%h b[31:0]=%h want 0", bus.mac_a[31:0], bus.mac_b[31:0]); end
        checks++; if (bus.rd_valid !== 2'b00 || bus.ovf !== 2'b00) begin errors++; $display("FAIL reset_flags got rd_valid=%b ovf=%b want 00/00", bus.rd_valid, bus.ovf); end
        bus.opa0 = '0;
    endtask

    task automatic test_basic_read();
        logic [1:0] want;
        bus.req = 2'b01;
        settle();
        checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL pre_grant gnt=%b want=00", bus.gnt); end
        tick();
        bus.rd_en = 2'b01; bus.addr0 = 11'h005;
        settle();
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL grant0 gnt=%b want=01", bus.gnt); end
        checks++; if (bus.rom_en !== 1'b1) begin errors++; $display("FAIL rd_rom_en got=%b want=1", bus.rom_en); end
        checks++; if (bus.rom_addr !== 11'h005) begin errors++; $display("FAIL rd_rom_addr got=%h want=005", bus.rom_addr); end
        tick();
        bus.rd_en = 2'b00;
        for (int k = 1; k <= ROM_LAT + 1; k++) begin
            bus.rom_data = rand_word();
            settle();
            want = (k == ROM_LAT) ? 2'b01 : 2'b00;
            checks++; if (bus.rd_valid !== want) begin errors++; $display("FAIL rd_valid_lat k=%0d got=%b want=%b", k, bus.rd_valid, want); end
            if (k == ROM_LAT) begin
                checks++; if (bus.rd_data !== bus.rom_data) begin errors++; $display("FAIL rd_data got[31:0]=%h want[31:0]=%h", bus.rd_data[31:0], bus.rom_data[31:0]); end
            end
            tick();
        end
        release_owner(0);
        settle();
        checks++; if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin errors++; $display("FAIL after_release busy=%b gnt=%b want 0/00", bus.busy, bus.gnt); end
    endtask

    task automatic test_round_robin();
        clear_inputs();
        iRst = 1'b1; tick(); iRst = 1'b0;
        bus.req = 2'b11; settle(); tick(); settle();
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rr_first gnt=%b want=01", bus.gnt); end
        release_owner(0);
        bus.req = 2'b11; settle(); tick(); settle();
        checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL rr_second gnt=%b want=10", bus.gnt); end
        release_owner(1);
        bus.req = 2'b11; settle(); tick(); settle();
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rr_third gnt=%b want=01", bus.gnt); end
        release_owner(0);
    endtask

    task automatic test_release_inflight();
        logic [1:0] want_g, want_v;
        bus.req = 2'b01; settle(); tick();
        bus.rd_en = 2'b01; bus.addr0 = 11'h3FF; bus.rel = 2'b01; bus.req = 2'b11;
        settle();
        checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 11'h3FF) begin errors++; $display("FAIL rel_rd_issue en=%b addr=%h want 1/3ff", bus.rom_en, bus.rom_addr); end
        tick();
        bus.rd_en = 2'b00; bus.rel = 2'b00; bus.req = 2'b10;
        for (int k = 1; k <= ROM_LAT + 2; k++) begin
            settle();
            want_g = (k == ROM_LAT + 2) ? 2'b10 : 2'b00;
            want_v = (k == ROM_LAT) ? 2'b01 : 2'b00;
            checks++; if (bus.gnt !== want_g) begin errors++; $display("FAIL drain_gnt k=%0d got=%b want=%b", k, bus.gnt, want_g); end
            checks++; if (bus.rd_valid !== want_v) begin errors++; $display("FAIL drain_rd_valid k=%0d got=%b want=%b", k, bus.rd_valid, want_v); end
            if (k <= ROM_LAT) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL drain_busy k=%0d got=%b want=1", k, bus.busy); end
            end
            tick();
        end
        release_owner(1);
    endtask

    task automatic test_overflow();
        bus.req = 2'b10; settle(); tick();
        bus.req = 2'b00; bus.mac_vld = 2'b10; bus.mac_ovf = 1'b1;
        settle();
        checks++; if (bus.ovf !== 2'b00) begin errors++; $display("FAIL ovf_before got=%b want=00", bus.ovf); end
        tick();
        bus.mac_vld = 2'b01;
        settle();
        checks++; if (bus.ovf !== 2'b10) begin errors++; $display("FAIL ovf_set got=%b want=10", bus.ovf); end
        tick();
        bus.mac_vld = 2'b10; bus.ovf_clr = 2'b10;
        settle();
        checks++; if (bus.ovf !== 2'b10) begin errors++; $display("FAIL ovf_nonowner got=%b want=10", bus.ovf); end
        tick();
        bus.mac_vld = 2'b00; bus.mac_ovf = 1'b0;
        settle();
        checks++; if (bus.ovf !== 2'b10) begin errors++; $display("FAIL ovf_set_wins got=%b want=10", bus.ovf); end
        tick();
        bus.ovf_clr = 2'b00;
        settle();
        checks++; if (bus.ovf !== 2'b00) begin errors++; $display("FAIL ovf_clear got=%b want=00", bus.ovf); end
        release_owner(1);
    endtask

    task automatic test_non_owner();
        logic [WORD_W-1:0] pa, pb;
        pa = rand_word(); pb = rand_word();
        bus.req = 2'b01; settle(); tick();
        bus.req = 2'b11; bus.rd_en = 2'b10; bus.rel = 2'b10; bus.mac_vld = 2'b10; bus.mac_ovf = 1'b1;
        bus.addr0 = 11'h123; bus.addr1 = 11'h7AA;
        bus.opa0 = pa; bus.opb0 = pb; bus.opa1 = '1; bus.opb1 = '1;
        settle();
        checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL nonowner_rom_en got=%b want=0", bus.rom_en); end
        checks++; if (bus.rom_addr !== 11'h123) begin errors++; $display("FAIL nonowner_addr got=%h want=123", bus.rom_addr); end
        checks++; if (bus.mac_a !== pa || bus.mac_b !== pb) begin errors++; $display("FAIL nonowner_mac got a[31:0]=%h want[31:0]=%h", bus.mac_a[31:0], pa[31:0]); end
        tick();
        clear_inputs();
        settle();
        checks++; if (bus.gnt !== 2'b01 || bus.ovf !== 2'b00) begin errors++; $display("FAIL nonowner_held gnt=%b ovf=%b want 01/00", bus.gnt, bus.ovf); end
        for (int k = 1; k <= ROM_LAT; k++) begin
            tick(); settle();
            checks++; if (bus.rd_valid !== 2'b00) begin errors++; $display("FAIL nonowner_rd_valid k=%0d got=%b want=00", k, bus.rd_valid); end
        end
        release_owner(0);
        bus.opa0 = '1; bus.addr0 = 11'h456;
        settle();
        checks++; if (bus.mac_a !== '0 || bus.rom_addr !== '0) begin errors++; $display("FAIL idle_mux mac_a[31:0]=%h addr=%h want 0/0", bus.mac_a[31:0], bus.rom_addr); end
        clear_inputs();
    endtask

    task automatic test_reset_midop();
        bus.req = 2'b01; settle(); tick();
        bus.req = 2'b00; bus.rd_en = 2'b01; bus.addr0 = 11'h055;
        settle(); tick();
        bus.rd_en = 2'b00; iRst = 1'b1;
        settle(); tick();
        iRst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++; if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_state k=%0d gnt=%b busy=%b want 00/0", k, bus.gnt, bus.busy); end
            checks++; if (bus.rd_valid !== 2'b00) begin errors++; $display("FAIL midrst_rd_valid k=%0d got=%b want=00", k, bus.rd_valid); end
            tick();
        end
    endtask

    task automatic test_random();
        clear_inputs();
        iRst = 1'b1; tick(); iRst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            bus.req      = 2'($urandom);
            bus.rel      = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            bus.rd_en    = 2'($urandom);
            bus.mac_vld  = 2'($urandom);
            bus.mac_ovf  = ($urandom_range(0, 3) == 0);
            bus.ovf_clr  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            bus.addr0    = ADDR_W'($urandom);
            bus.addr1    = ADDR_W'($urandom);
            bus.mac_res  = RES_W'($urandom);
            if (n % 4 == 0) begin
                bus.opa0 = rand_word(); bus.opa1 = rand_word();
                bus.opb0 = rand_word(); bus.opb1 = rand_word();
            end
            bus.rom_data = rand_word();
            iRst = ($urandom_range(0, 63) == 0);
            settle();
            checks++; if (bus.gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt n=%0d got=%b want=%b", n, bus.gnt, exp_gnt); end
            checks++; if (bus.rom_en !== exp_rom_en) begin errors++; $display("FAIL rnd_rom_en n=%0d got=%b want=%b", n, bus.rom_en, exp_rom_en); end
            checks++; if (bus.rom_addr !== exp_rom_addr) begin errors++; $display("FAIL rnd_rom_addr n=%0d got=%h want=%h", n, bus.rom_addr, exp_rom_addr); end
            checks++; if (bus.mac_a !== exp_mac_a || bus.mac_b !== exp_mac_b) begin errors++; $display("FAIL rnd_mac n=%0d a[31:0]=%h want[31:0]=%h", n, bus.mac_a[31:0], exp_mac_a[31:0]); end
            checks++; if (bus.rd_valid !== exp_rd_valid) begin errors++; $display("FAIL rnd_rd_valid n=%0d got=%b want=%b", n, bus.rd_valid, exp_rd_valid); end
            checks++; if (bus.rd_data !== bus.rom_data || bus.res_data !== bus.mac_res) begin errors++; $display("FAIL rnd_bcast n=%0d res=%h want=%h", n, bus.res_data, bus.mac_res); end
            checks++; if (bus.ovf !== exp_ovf) begin errors++; $display("FAIL rnd_ovf n=%0d got=%b want=%b", n, bus.ovf, exp_ovf); end
            checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL rnd_busy n=%0d got=%b want=%b", n, bus.busy, exp_busy); end
            tick();
        end
        iRst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_read();
        test_round_robin();
        test_release_inflight();
        test_overflow();
        test_non_owner();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
